iotdf_src_arb: RTL
==================

# iotdf_src_arb

Front-end scheduler for the IOTDF datapath. It arbitrates up to NSRC sensor requesters, each offering one 128-bit item, and serializes the granted item into the 8-bit `in_en`/`iot_in` stream, most significant byte first. It drives a held `fn_sel`, honours DUT `busy`, and registers the DUT's `valid`/`iot_out` results, with a result counter, toward the system bus.

## Interface
- NSRC, 4: number of requesters (2..8)
- ROUND_ITEMS, 8: items per round; a round-done pulse follows each group
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- en  in  1  scheduler enable
- fn_cfg  in  3  function code for the DUT
- fn_cfg_we  in  1  config write strobe; honoured only in IDLE
- src_req  in  NSRC  per-source request; level, held until granted
- src_data  in  NSRC*128  item of source k at bits [128k+127:128k]
- src_gnt  out  NSRC  one-hot, one-cycle pulse; item latched that cycle
- in_en  out  1  byte strobe to DUT
- iot_in  out  8  byte to DUT
- fn_sel  out  3  function code to DUT, held from config register
- busy  in  1  DUT stall
- valid  in  1  DUT result strobe
- iot_out  in  128  DUT result
- res_valid  out  1  registered copy of `valid`
- res_data  out  128  `iot_out` captured when `valid`=1; holds otherwise
- res_count  out  16  results since last config write; saturates at 16'hFFFF
- round_done  out  1  one-cycle pulse after every ROUND_ITEMS-th item's last byte

## Operation
- States are IDLE, SEND and DRAIN.
- **IDLE**
  - `fn_cfg_we`=1 loads `fn_sel`←`fn_cfg` and clears `res_count` and the item counter.
  - If `en`=1 and any `src_req` is set, the arbiter picks a winner. The same cycle pulses `src_gnt`, latches that source's 128 bits into the shift register, sets byte index to 0 and moves to SEND.
  - A write and a grant in the same cycle are both performed. The new `fn_sel` is visible with byte 0.
- **SEND**
  - Each cycle with `busy`=0: `in_en`=1, `iot_in`=shift[127:120], shift left 8, index+1.
  - Each cycle with `busy`=1: `in_en`=0, and index and shift register hold.
  - On byte 15 (index 15, `busy`=0):
    - Item counter increments. When it reaches ROUND_ITEMS it wraps to 0 and `round_done` pulses next cycle.
    - If `en`=1 and a request is pending: re-arbitrate in that same cycle, pulse `src_gnt`, load the new item and stay in SEND. Byte 0 follows with no bubble.
    - Otherwise: if `en`=0 → DRAIN, else → IDLE.
- **DRAIN**
  - `in_en`=0.
  - Waits until `valid`=0 for 2 consecutive cycles, then → IDLE.
- **Items and enable**
  - Deasserting `src_req` or `en` mid-item never truncates an item. All 16 bytes are always sent.
  - `fn_cfg_we` outside IDLE is ignored.
- **Arbitration**
  - Round-robin. The pointer is set to one past the last grant, modulo NSRC, and the search starts at the pointer.
  - Reset pointer is 0.
- **Result capture**
  - Every cycle: `res_valid`←`valid`.
  - If `valid`=1: `res_data`←`iot_out`, and `res_count` increments unless it is at 16'hFFFF.
  - Capture runs in every state.
- **Reset values**
  - State IDLE.
  - `src_gnt`=0, `in_en`=0, `iot_in`=0, `fn_sel`=0.
  - `res_valid`=0, `res_data`=0, `res_count`=0, `round_done`=0.
  - Pointer 0, item counter 0.
- **Reset mid-item:** `in_en` is 0 in the cycle after the reset edge. The partial item is discarded and not re-requested.

## Timing
- Grant at cycle t → byte 0 (`in_en`=1) at t+1.
- Byte 15 at t+16 if `busy` stays low. Each `busy` cycle adds one.
- Back-to-back items: the next `src_gnt` coincides with byte 15, and its byte 0 is at t+17.
- All outputs are registered and there are no combinational input-to-output paths.
- `res_valid`/`res_data` lag `valid`/`iot_out` by one cycle.
- `round_done` asserts the cycle after the round's final byte.

## Configuration
- `IOTDF_ARB_FIXED_PRI_EN`
  - Defined: fixed priority, where the lowest-index requester always wins and the pointer is unused.
  - Undefined (default): round-robin as above.

## Test plan
- Reset, then source 0 requests with 128'h00112233_44556677_8899AABB_CCDDEEFF and `busy`=0 → `src_gnt`=4'b0001. Bytes 00,11,…,FF appear on 16 consecutive cycles starting grant+1. State returns to IDLE.
- Sources 0–3 all request continuously, 8 items → grants in order 0,1,2,3,0,1,2,3. `in_en` is never low between items. `round_done` pulses once, one cycle after byte 128.
- `busy` high for 3 cycles at byte 5 → `in_en`=0 for exactly those 3 cycles. Byte 5 value is unchanged and the item completes at grant+19.
- `fn_cfg`=3'd3 written in IDLE together with a request → `fn_sel`=3 from the byte-0 cycle. A write of 3'd5 during SEND leaves `fn_sel`=3.
- DUT `valid` pulse with `iot_out`=128'hAFFF…F → `res_valid`=1 next cycle with the same data. `res_count` goes from 0 to 1. Starting from 16'hFFFF, a pulse keeps it at 16'hFFFF.
- `rst_n` low at byte 7 → next cycle `in_en`=0, `src_gnt`=0 and `res_count`=0. A fresh request restarts at byte 0 of the new item.

Source files
------------

// File: rtl/iotdf_src_arb.sv
// IOTDF front-end scheduler: round-robin over NSRC requesters, 128-bit item -> 16 MSB-first bytes.
// Define IOTDF_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module iotdf_src_arb #(
   parameter int NSRC        = 4,
   parameter int ROUND_ITEMS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [2:0]           fn_cfg,
   input  logic                 fn_cfg_we,
   input  logic [NSRC-1:0]      src_req,
   input  logic [NSRC*128-1:0]  src_data,
   output logic [NSRC-1:0]      src_gnt,
   output logic                 in_en,
   output logic [7:0]           iot_in,
   output logic [2:0]           fn_sel,
   input  logic                 busy,
   input  logic                 valid,
   input  logic [127:0]         iot_out,
   output logic                 res_valid,
   output logic [127:0]         res_data,
   output logic [15:0]          res_count,
   output logic                 round_done
);

   localparam int PW = $clog2(NSRC);
   localparam int CW = $clog2(ROUND_ITEMS + 1);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [127:0]    r_shift;
   logic [3:0]      r_idx;
   logic [CW-1:0]   r_item_cnt;
   logic            r_rd_pend;
   logic            r_vlow;

   logic            w_any;
   logic [PW-1:0]   w_win;
   logic [NSRC-1:0] w_onehot;
   logic [127:0]    w_item;
   logic [PW-1:0]   w_ptr_nxt;
   logic            w_last_cnt;

   always_comb begin
      w_any = 1'b0;
      w_win = '0;
`ifdef IOTDF_ARB_FIXED_PRI_EN
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (src_req[i]) begin
            w_any = 1'b1;
            w_win = PW'(i);
         end
      end
`else
      // Search starts at the pointer and wraps; first hit wins.
      for (int i = 0; i < NSRC; i++) begin
         if (!w_any && src_req[(int'(r_ptr) + i) % NSRC]) begin
            w_any = 1'b1;
            w_win = PW'((int'(r_ptr) + i) % NSRC);
         end
      end
`endif
   end

   assign w_onehot   = NSRC'(1) << w_win;
   assign w_item     = src_data[int'(w_win)*128 +: 128];
   assign w_ptr_nxt  = (int'(w_win) == NSRC - 1) ? '0 : w_win + 1'b1;
   assign w_last_cnt = (r_item_cnt == CW'(ROUND_ITEMS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_shift    <= '0;
         r_idx      <= '0;
         r_item_cnt <= '0;
         r_rd_pend  <= 1'b0;
         r_vlow     <= 1'b0;
         src_gnt    <= '0;
         in_en      <= 1'b0;
         iot_in     <= '0;
         fn_sel     <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_count  <= '0;
         round_done <= 1'b0;
      end else begin
         src_gnt    <= '0;
         in_en      <= 1'b0;
         r_rd_pend  <= 1'b0;
         round_done <= r_rd_pend;
         res_valid  <= valid;
         if (valid) res_data <= iot_out;
         // A coincident result still counts toward the freshly cleared total.
         if (r_state == IDLE && fn_cfg_we)
            res_count <= {15'd0, valid};
         else if (valid && res_count != 16'hFFFF)
            res_count <= res_count + 16'd1;

         case (r_state)
            IDLE: begin
               if (fn_cfg_we) begin
                  fn_sel     <= fn_cfg;
                  r_item_cnt <= '0;
               end
               if (en && w_any) begin
                  src_gnt <= w_onehot;
                  r_shift <= w_item;
                  r_idx   <= '0;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (!busy) begin
                  in_en   <= 1'b1;
                  iot_in  <= r_shift[127:120];
                  r_shift <= {r_shift[119:0], 8'h00};
                  r_idx   <= r_idx + 4'd1;
                  if (r_idx == 4'd15) begin
                     if (w_last_cnt) begin
                        r_item_cnt <= '0;
                        r_rd_pend  <= 1'b1;
                     end else begin
                        r_item_cnt <= r_item_cnt + CW'(1);
                     end
                     // Next item loads under byte 15 so its byte 0 follows with no bubble.
                     if (en && w_any) begin
                        src_gnt <= w_onehot;
                        r_shift <= w_item;
                        r_idx   <= '0;
                        r_ptr   <= w_ptr_nxt;
                     end else if (!en) begin
                        r_vlow  <= 1'b0;
                        r_state <= DRAIN;
                     end else begin
                        r_state <= IDLE;
                     end
                  end
               end
            end
            DRAIN: begin
               if (!valid) begin
                  if (r_vlow) r_state <= IDLE;
                  r_vlow <= 1'b1;
               end else begin
                  r_vlow <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
